// File: rtl/clock_tick_gen.sv
// clock_tick_gen: multi-channel programmable clock-enable generator with tick strobes and square waves
module clock_tick_gen #(
    parameter int CNT_W       = 27,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] done
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d, act_div_q, act_div_d, shd_div_q, shd_div_d, term;
        logic             mode_q, mode_d, tick_q, tick_d, sq_q, sq_d, done_q, done_d;
        logic             tc, wr;
        // a divisor of 0 behaves as 1, so the terminal count is 0 in both cases
        assign term = (act_div_q == '0) ? '0 : act_div_q - 1'b1;
        assign wr   = cfg_wr && (cfg_ch == CH_W'(i));
        assign tc   = en[i] && !done_q && (cnt_q == term);
        // next state: count, fire at terminal count, swap in the shadow divisor on period boundaries
        always_comb begin
            cnt_d     = (!en[i] || tc || done_q) ? '0 : cnt_q + 1'b1;
            tick_d    = tc;
            sq_d      = sq_q ^ tc;
            done_d    = en[i] && !wr && (done_q || (tc && mode_q));
            act_div_d = (wr && (tc || !en[i] || done_q)) ? cfg_div : tc ? shd_div_q : act_div_q;
            shd_div_d = wr ? cfg_div : shd_div_q;
            mode_d    = wr ? cfg_oneshot : mode_q;
        end
        // channel state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q     <= '0;
                act_div_q <= CNT_W'(DEFAULT_DIV);
                shd_div_q <= CNT_W'(DEFAULT_DIV);
                mode_q    <= 1'b0;
                tick_q    <= 1'b0;
                sq_q      <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                act_div_q <= act_div_d;
                shd_div_q <= shd_div_d;
                mode_q    <= mode_d;
                tick_q    <= tick_d;
                sq_q      <= sq_d;
                done_q    <= done_d;
            end
        end
        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
        assign done[i] = done_q;
    end
endmodule

// File: tb/tb_clock_tick_gen.sv
// tb_clock_tick_gen: directed self-checking bench for clock_tick_gen
module tb_clock_tick_gen;
    localparam int CNT_W = 8;
    localparam int NUM_CH = 3;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] tick, sq, done;

    int n_assert = 0;
    int n_fail = 0;
    logic [NUM_CH-1:0] exp_sq;
    logic t0, t1;

    clock_tick_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .DEFAULT_DIV(4), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .tick(tick), .sq(sq), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input logic t, input logic s, input logic d);
        chk({tag, "_tick"}, tick[ch], t);
        chk({tag, "_sq"}, sq[ch], s);
        chk({tag, "_done"}, done[ch], d);
    endtask

    initial begin
        reset = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
        exp_sq = '0;
        step();
        step();
        for (int c = 0; c < NUM_CH; c++) chk_ch("reset", c, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        en = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            step();
            t0 = (k % 4 == 0);
            exp_sq[0] ^= t0;
            chk_ch("div4", 0, t0, exp_sq[0], 1'b0);
        end
        for (int k = 13; k <= 28; k++) begin
            if (k == 15) begin cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; end
            step();
            cfg_wr = 1'b0;
            t0 = (k inside {16, 22, 28});
            exp_sq[0] ^= t0;
            chk_ch("div4to6", 0, t0, exp_sq[0], 1'b0);
        end
        en = 3'b000; cfg_wr = 1'b1; cfg_div = 8'd0;
        step();
        cfg_wr = 1'b0;
        chk_ch("div0_stop", 0, 1'b0, exp_sq[0], 1'b0);
        en = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin cfg_wr = 1'b1; cfg_div = 8'd1; end
            step();
            cfg_wr = 1'b0;
            exp_sq[0] ^= 1'b1;
            chk_ch("div0_1", 0, 1'b1, exp_sq[0], 1'b0);
        end
        en = 3'b000; cfg_wr = 1'b1; cfg_div = 8'd5; cfg_oneshot = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk_ch("os_cfg", 0, 1'b0, exp_sq[0], 1'b0);
        en = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            step();
            t0 = (k == 5);
            exp_sq[0] ^= t0;
            chk_ch("os_a", 0, t0, exp_sq[0], k >= 5);
        end
        en = 3'b000;
        step();
        chk_ch("os_drop", 0, 1'b0, exp_sq[0], 1'b0);
        en = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            step();
            t0 = (k == 5);
            exp_sq[0] ^= t0;
            chk_ch("os_b", 0, t0, exp_sq[0], k >= 5);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_sq = '0;
        chk_ch("reset2", 0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            t0 = (k == 4);
            exp_sq[0] ^= t0;
            chk_ch("pre_rst", 0, t0, exp_sq[0], 1'b0);
        end
        reset = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_oneshot = 1'b1;
        step();
        reset = 1'b0; cfg_wr = 1'b0;
        exp_sq = '0;
        chk_ch("mid_rst", 0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            t0 = (k % 4 == 0);
            exp_sq[0] ^= t0;
            chk_ch("post_rst", 0, t0, exp_sq[0], 1'b0);
        end
        en = 3'b000; cfg_wr = 1'b1; cfg_oneshot = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd3;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_ch = 2'd3; cfg_div = 8'd2;
        step();
        cfg_wr = 1'b0;
        chk_ch("mc_idle1", 1, 1'b0, 1'b0, 1'b0);
        en = 3'b011;
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) begin cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; end
            step();
            cfg_wr = 1'b0;
            t0 = (k % 3 == 0);
            t1 = (k inside {5, 10, 12, 14, 16});
            exp_sq[0] ^= t0;
            exp_sq[1] ^= t1;
            chk_ch("mc_ch0", 0, t0, exp_sq[0], 1'b0);
            chk_ch("mc_ch1", 1, t1, exp_sq[1], 1'b0);
            chk_ch("mc_ch2", 2, 1'b0, 1'b0, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
